// File: rtl/cl_wavefront_crawler.sv
// Anti-diagonal wavefront walker over an (X+1)x(Y+1) grid, emitting LANES cells per group.
// Optional abort input is enabled by defining CL_WAVEFRONT_CRAWLER_ABORT_EN.
module cl_wavefront_crawler #(
  parameter int COORD_W = 8,
  parameter int LANES   = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
`ifdef CL_WAVEFRONT_CRAWLER_ABORT_EN
  input  logic               abort_i,
`endif
  input  logic               start_i,
  input  logic [COORD_W-1:0] dim_x_i,
  input  logic [COORD_W-1:0] dim_y_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [COORD_W-1:0] base_x_o,
  output logic [COORD_W-1:0] base_y_o,
  output logic [LANES-1:0]   lane_mask_o,
  output logic               diag_last_o,
  output logic [COORD_W:0]   diag_idx_o
);
  localparam int W1 = COORD_W + 1;
  localparam logic [COORD_W:0]   LANES_W = W1'(LANES);
  localparam logic [COORD_W-1:0] LANES_N = COORD_W'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] dim_x_q, dim_x_d, dim_y_q, dim_y_d;
  logic [COORD_W-1:0] base_x_q, base_x_d, base_y_q, base_y_d;
  logic [COORD_W:0]   diag_q, diag_d;

  logic             abort_w;
  logic             run_w, lane_last_w;
  logic [COORD_W:0] bx_w, by_w, xmax_w, ymax_w, room_y_w, rem_w, diag_max_w;
  logic [COORD_W:0] next_d_w, next_x_w;
  logic [LANES-1:0] mask_w;

`ifdef CL_WAVEFRONT_CRAWLER_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // All remainder/diagonal arithmetic is one bit wider so X=Y=max cannot wrap.
  assign bx_w       = {1'b0, base_x_q};
  assign by_w       = {1'b0, base_y_q};
  assign xmax_w     = {1'b0, dim_x_q};
  assign ymax_w     = {1'b0, dim_y_q};
  assign room_y_w   = ymax_w - by_w;
  assign rem_w      = ((bx_w < room_y_w) ? bx_w : room_y_w) + W1'(1);
  assign diag_max_w = xmax_w + ymax_w;
  assign next_d_w   = diag_q + W1'(1);
  assign next_x_w   = (next_d_w < xmax_w) ? next_d_w : xmax_w;
  assign lane_last_w = (rem_w <= LANES_W);
  assign run_w       = (state_q == S_RUN);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      mask_w[k] = (bx_w >= W1'(k)) && ((by_w + W1'(k)) <= ymax_w);
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    dim_x_d  = dim_x_q;
    dim_y_d  = dim_y_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    diag_d   = diag_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_RUN;
          dim_x_d  = dim_x_i;
          dim_y_d  = dim_y_i;
          base_x_d = '0;
          base_y_d = '0;
          diag_d   = '0;
        end
      end
      S_RUN: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (ready_i) begin
          if (!lane_last_w) begin
            base_x_d = base_x_q - LANES_N;
            base_y_d = base_y_q + LANES_N;
          end else if (diag_q == diag_max_w) begin
            state_d = S_DONE;
          end else begin
            diag_d   = next_d_w;
            base_x_d = COORD_W'(next_x_w);
            base_y_d = COORD_W'(next_d_w - next_x_w);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      dim_x_q  <= '0;
      dim_y_q  <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      diag_q   <= '0;
    end else begin
      state_q  <= state_d;
      dim_x_q  <= dim_x_d;
      dim_y_q  <= dim_y_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      diag_q   <= diag_d;
    end
  end

  // Group outputs read zero outside RUN, so reset clears them without a clock edge.
  assign valid_o     = run_w;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign base_x_o    = run_w ? base_x_q : '0;
  assign base_y_o    = run_w ? base_y_q : '0;
  assign lane_mask_o = run_w ? mask_w : '0;
  assign diag_last_o = run_w && lane_last_w;
  assign diag_idx_o  = run_w ? diag_q : '0;

endmodule

// File: tb/tb_cl_wavefront_crawler.sv
// Self-checking bench: two crawler instances (COORD_W=8/LANES=4 and COORD_W=3/LANES=2)
// compared against a queue of groups built directly from the traversal rules.
module tb_cl_wavefront_crawler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  bit         sel = 1'b0;
  logic [7:0] dim_xa = '0, dim_ya = '0;
  logic [2:0] dim_xb = '0, dim_yb = '0;
`ifdef CL_WAVEFRONT_CRAWLER_ABORT_EN
  logic       abort_a = 1'b0;
  logic       abort_b = 1'b0;
`endif

  logic       busy_a, done_a, valid_a, last_a;
  logic [7:0] bx_a, by_a;
  logic [3:0] mask_a;
  logic [8:0] d_a;
  logic       busy_b, done_b, valid_b, last_b;
  logic [2:0] bx_b, by_b;
  logic [1:0] mask_b;
  logic [3:0] d_b;

  cl_wavefront_crawler #(.COORD_W(8), .LANES(4)) u_dut_a (
    .clock_i(clk), .reset_i(rst),
`ifdef CL_WAVEFRONT_CRAWLER_ABORT_EN
    .abort_i(abort_a),
`endif
    .start_i(start && !sel), .dim_x_i(dim_xa), .dim_y_i(dim_ya),
    .busy_o(busy_a), .done_o(done_a), .valid_o(valid_a), .ready_i(ready),
    .base_x_o(bx_a), .base_y_o(by_a), .lane_mask_o(mask_a),
    .diag_last_o(last_a), .diag_idx_o(d_a)
  );

  cl_wavefront_crawler #(.COORD_W(3), .LANES(2)) u_dut_b (
    .clock_i(clk), .reset_i(rst),
`ifdef CL_WAVEFRONT_CRAWLER_ABORT_EN
    .abort_i(abort_b),
`endif
    .start_i(start && sel), .dim_x_i(dim_xb), .dim_y_i(dim_yb),
    .busy_o(busy_b), .done_o(done_b), .valid_o(valid_b), .ready_i(ready),
    .base_x_o(bx_b), .base_y_o(by_b), .lane_mask_o(mask_b),
    .diag_last_o(last_b), .diag_idx_o(d_b)
  );

  always #5 clk = ~clk;

  logic [31:0] o_valid, o_busy, o_done, o_last, o_bx, o_by, o_mask, o_d;
  always_comb begin
    o_valid = sel ? 32'(valid_b) : 32'(valid_a);
    o_busy  = sel ? 32'(busy_b)  : 32'(busy_a);
    o_done  = sel ? 32'(done_b)  : 32'(done_a);
    o_last  = sel ? 32'(last_b)  : 32'(last_a);
    o_bx    = sel ? 32'(bx_b)    : 32'(bx_a);
    o_by    = sel ? 32'(by_b)    : 32'(by_a);
    o_mask  = sel ? 32'(mask_b)  : 32'(mask_a);
    o_d     = sel ? 32'(d_b)     : 32'(d_a);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  typedef struct {
    int bx;
    int by;
    int mask;
    int last;
    int d;
  } grp_t;
  grp_t exp_q[$];

  // Walk each anti-diagonal as a list of cells and chop it into LANES-sized groups.
  task automatic build_model(input int xm, input int ym, input int lanes);
    int x, y, n, take;
    grp_t g;
    exp_q.delete();
    for (int d = 0; d <= xm + ym; d++) begin
      x = (d < xm) ? d : xm;
      y = d - x;
      n = ((x < ym - y) ? x : ym - y) + 1;
      while (n > 0) begin
        take   = (n < lanes) ? n : lanes;
        g.bx   = x;
        g.by   = y;
        g.mask = (1 << take) - 1;
        g.last = (n <= lanes) ? 1 : 0;
        g.d    = d;
        exp_q.push_back(g);
        x -= take;
        y += take;
        n -= take;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_last"}, o_last, 0);
    check({tag, "_bx"}, o_bx, 0);
    check({tag, "_by"}, o_by, 0);
    check({tag, "_mask"}, o_mask, 0);
    check({tag, "_d"}, o_d, 0);
  endtask

  // mode 0: ready always high; 1: random ready and stray start; 2: ready low for cycles 3..5.
  task automatic run(input bit s, input int xm, input int ym, input int mode);
    int   cycles, ngroups, budget;
    grp_t g;
    sel = s;
    build_model(xm, ym, s ? 2 : 4);
    ngroups = exp_q.size();
    budget  = ngroups * 8 + 50;
    @(negedge clk);
    if (s) begin dim_xb = 3'(xm); dim_yb = 3'(ym); end
    else   begin dim_xa = 8'(xm); dim_ya = 8'(ym); end
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dim_xa = 8'($urandom);
    dim_ya = 8'($urandom);
    dim_xb = 3'($urandom);
    dim_yb = 3'($urandom);
    check("first_valid", o_valid, 1);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < budget) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = !(cycles >= 3 && cycles < 6);
      endcase
      if (mode == 1) start = 1'($urandom_range(0, 1));
      g = exp_q[0];
      check("valid", o_valid, 1);
      check("busy", o_busy, 1);
      check("done_early", o_done, 0);
      check("base_x", o_bx, g.bx);
      check("base_y", o_by, g.by);
      check("mask", o_mask, g.mask);
      check("diag_last", o_last, g.last);
      check("diag_idx", o_d, g.d);
      if (ready) void'(exp_q.pop_front());
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    check("groups_left", exp_q.size(), 0);
    if (mode == 0) check("back_to_back_cycles", cycles, ngroups);
    check("done_pulse", o_done, 1);
    check("done_valid", o_valid, 0);
    check("done_busy", o_busy, 1);
    @(negedge clk);
    check_idle_outputs("after_done");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    run(0, 0, 0, 0);
    run(0, 2, 2, 0);
    run(1, 3, 3, 0);
    run(0, 2, 2, 2);
    run(0, 9, 4, 2);
    run(1, 7, 7, 1);
    for (int i = 0; i < 4; i++) run(0, $urandom_range(0, 11), $urandom_range(0, 11), 1);
    for (int i = 0; i < 3; i++) run(1, $urandom_range(0, 7), $urandom_range(0, 7), 1);
    run(0, 255, 255, 0);

    // Reset between clock edges mid-run, then a fresh start from d=0.
    sel = 1'b0;
    @(negedge clk);
    dim_xa = 8'd5;
    dim_ya = 8'd5;
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_valid", o_valid, 1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_reset");
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    @(negedge clk);
    check("post_reset_no_done", o_done, 0);
    run(0, 5, 5, 1);

`ifdef CL_WAVEFRONT_CRAWLER_ABORT_EN
    sel = 1'b0;
    @(negedge clk);
    dim_xa = 8'd3;
    dim_ya = 8'd3;
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_third_d", o_d, 2);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check_idle_outputs("aborted");
    @(negedge clk);
    check("abort_no_done", o_done, 0);
    run(0, 3, 3, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
